regression_driver: RTL

- Initiator side of the regression engine's start/ready handshake.
- On a host `go` request, it issues a correctly shaped `start` pulse to the engine and tracks the engine through its busy period.
- During the run it captures the engine's per-sample error strobes and keeps running error statistics; on completion it latches beta0/beta1 and reports done.
- Sits between the host/test sequencer and the regression engine's controller/datapath.

---
 rtl/regression_driver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/regression_driver.sv
// Start/ready initiator for the regression engine: pulses start, tracks the busy period, gathers error stats, latches betas.
// Optional watchdog abort is built when REGDRV_TIMEOUT_EN is defined; otherwise timeout is tied 0.
module regression_driver #(
    parameter int DATA_W         = 20,
    parameter int N_SAMPLES      = 150,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    output logic                busy,
    output logic                done,
    output logic                start,
    input  logic                ready,
    input  logic [DATA_W-1:0]   beta0_in,
    input  logic [DATA_W-1:0]   beta1_in,
    input  logic                err_valid,
    input  logic [DATA_W-1:0]   err_in,
    output logic [DATA_W-1:0]   beta0,
    output logic [DATA_W-1:0]   beta1,
    output logic [7:0]          err_count,
    output logic [DATA_W+7:0]   err_sum,
    output logic [DATA_W-1:0]   err_max,
    output logic                count_ok,
    output logic                timeout
);

    localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_BUSY, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       st_cnt_q, st_cnt_d;
    logic [DATA_W-1:0]   beta0_q, beta0_d, beta1_q, beta1_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W+7:0]   sum_q, sum_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic                ok_q, ok_d;
    logic [DATA_W-1:0]   abs_err;
    logic                accept, sample, finish, tmo_fire;

    assign accept  = (state_q == S_IDLE) && go && ready;
    assign sample  = (state_q == S_RUN) && err_valid;
    assign finish  = (state_q == S_RUN) && ready;
    // Unsigned magnitude: the most negative input maps to 2^(DATA_W-1) without overflow.
    assign abs_err = err_in[DATA_W-1] ? (~err_in + DATA_W'(1)) : err_in;

`ifdef REGDRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_q;
    logic          tmo_hit;

    assign tmo_hit  = ((state_q == S_WAIT_BUSY) || (state_q == S_RUN)) &&
                      (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign tmo_fire = tmo_hit && !finish;
    assign timeout  = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept)
                tmo_cnt_q <= '0;
            else if ((state_q == S_WAIT_BUSY) || (state_q == S_RUN))
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (accept)
                timeout_q <= 1'b0;
            else if (tmo_fire)
                timeout_q <= 1'b1;
        end
    end
`else
    logic unused_tmo_param;
    assign unused_tmo_param = ^TIMEOUT_CYCLES;
    assign tmo_fire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            st_cnt_q <= '0;
            beta0_q  <= '0;
            beta1_q  <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            max_q    <= '0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            st_cnt_q <= st_cnt_d;
            beta0_q  <= beta0_d;
            beta1_q  <= beta1_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            max_q    <= max_d;
            ok_q     <= ok_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        st_cnt_d = '0;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_START;
            S_START: begin
                if (st_cnt_q == SW'(START_CYCLES - 1))
                    state_d = S_WAIT_BUSY;
                else
                    st_cnt_d = st_cnt_q + SW'(1);
            end
            S_WAIT_BUSY: begin
                if (tmo_fire)
                    state_d = S_DONE;
                else if (!ready)
                    state_d = S_RUN;
            end
            S_RUN:       if (finish || tmo_fire) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start = (state_q == S_START);
        busy  = (state_q == S_START) || (state_q == S_WAIT_BUSY) || (state_q == S_RUN);
        done  = (state_q == S_DONE);
    end

    // A strobe coincident with ready's return is folded in before count_ok is judged.
    always_comb begin
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        max_d   = max_q;
        ok_d    = ok_q;
        beta0_d = beta0_q;
        beta1_d = beta1_q;
        if (accept) begin
            cnt_d = '0;
            sum_d = '0;
            max_d = '0;
            ok_d  = 1'b0;
        end
        if (sample) begin
            if (cnt_q != 8'hFF)
                cnt_d = cnt_q + 8'd1;
            sum_d = sum_q + (DATA_W+8)'(abs_err);
            if (abs_err > max_q)
                max_d = abs_err;
        end
        if (finish) begin
            beta0_d = beta0_in;
            beta1_d = beta1_in;
            ok_d    = (32'(cnt_d) == 32'(N_SAMPLES));
        end
    end

    assign beta0     = beta0_q;
    assign beta1     = beta1_q;
    assign err_count = cnt_q;
    assign err_sum   = sum_q;
    assign err_max   = max_q;
    assign count_ok  = ok_q;

endmodule
